// File: rtl/multicycle_ctrl_fsm_if.sv
// Memory handshake between the multicycle controller and the memory system.
interface multicycle_ctrl_fsm_if;
  logic mem_req;
  logic mem_ready;

  modport master (output mem_req, input mem_ready);
  modport slave  (input mem_req, output mem_ready);
endinterface

// File: rtl/multicycle_ctrl_fsm.sv
// Main controller for the multicycle RV32I datapath: sequences each instruction class,
// drives mux selects and write strobes, stalls on the memory handshake, traps on faults.
module multicycle_ctrl_fsm #(
  parameter int MEM_TIMEOUT  = 16,
  parameter bit ILLEGAL_TRAP = 1'b1,
  parameter int CNT_W        = 5
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic [6:0]                   op,
  multicycle_ctrl_fsm_if.master        mem,
  output logic                         AdrSrc,
  output logic                         IRWrite,
  output logic                         PCUpdate,
  output logic                         Branch,
  output logic                         MemWrite,
  output logic                         RegWrite,
  output logic [1:0]                   ResultSrc,
  output logic [1:0]                   ALUSrcA,
  output logic [1:0]                   ALUSrcB,
  output logic [1:0]                   ALUOp,
  output logic                         illegal_op,
  output logic                         bus_err,
  output logic [3:0]                   state_o
);

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEMADR   = 4'd2,
    S_MEMREAD  = 4'd3,
    S_MEMWB    = 4'd4,
    S_MEMWRITE = 4'd5,
    S_EXECR    = 4'd6,
    S_EXECI    = 4'd7,
    S_ALUWB    = 4'd8,
    S_BEQ      = 4'd9,
    S_JAL      = 4'd10,
    S_TRAP     = 4'd15
  } state_t;

  typedef struct packed {
    logic       mem_req;
    logic       adr_src;
    logic       ir_write;
    logic       pc_update;
    logic       branch;
    logic       mem_write;
    logic       reg_write;
    logic [1:0] result_src;
    logic [1:0] alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] alu_op;
  } ctrl_t;

  localparam logic [6:0] OP_LOAD  = 7'b0000011;
  localparam logic [6:0] OP_STORE = 7'b0100011;
  localparam logic [6:0] OP_RTYPE = 7'b0110011;
  localparam logic [6:0] OP_ITYPE = 7'b0010011;
  localparam logic [6:0] OP_BEQ   = 7'b1100011;
  localparam logic [6:0] OP_JAL   = 7'b1101111;

  localparam bit             TMO_EN   = (MEM_TIMEOUT != 0);
  localparam logic [CNT_W-1:0] TMO_LAST = CNT_W'(MEM_TIMEOUT - 1);

  state_t           state_reg, state_next;
  logic [CNT_W-1:0] cnt_reg, cnt_next;
  logic             illegal_op_reg, illegal_op_next;
  logic             bus_err_reg, bus_err_next;
  logic             in_mem;
  logic             mem_wait;
  ctrl_t            ctrl_comb;
  ctrl_t            ctrl_out;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg      <= S_FETCH;
      cnt_reg        <= '0;
      illegal_op_reg <= 1'b0;
      bus_err_reg    <= 1'b0;
    end else begin
      state_reg      <= state_next;
      cnt_reg        <= cnt_next;
      illegal_op_reg <= illegal_op_next;
      bus_err_reg    <= bus_err_next;
    end
  end

  always_comb begin
    state_next      = state_reg;
    illegal_op_next = illegal_op_reg;
    bus_err_next    = bus_err_reg;
    ctrl_comb       = '0;
    in_mem          = 1'b0;
    mem_wait        = 1'b0;
    cnt_next        = cnt_reg;

    case (state_reg)
      S_FETCH: begin
        in_mem               = 1'b1;
        ctrl_comb.mem_req    = 1'b1;
        ctrl_comb.alu_src_b  = 2'b10;
        ctrl_comb.result_src = 2'b10;
        ctrl_comb.ir_write   = mem.mem_ready;
        ctrl_comb.pc_update  = mem.mem_ready;
        if (mem.mem_ready) state_next = S_DECODE;
      end
      S_DECODE: begin
        ctrl_comb.alu_src_a = 2'b01;
        ctrl_comb.alu_src_b = 2'b01;
        case (op)
          OP_LOAD, OP_STORE: state_next = S_MEMADR;
          OP_RTYPE:          state_next = S_EXECR;
          OP_ITYPE:          state_next = S_EXECI;
          OP_BEQ:            state_next = S_BEQ;
          OP_JAL:            state_next = S_JAL;
          default: begin
            if (ILLEGAL_TRAP) begin
              state_next      = S_TRAP;
              illegal_op_next = 1'b1;
            end else begin
              state_next = S_FETCH;
            end
          end
        endcase
      end
      S_MEMADR: begin
        ctrl_comb.alu_src_a = 2'b10;
        ctrl_comb.alu_src_b = 2'b01;
        state_next = (op == OP_LOAD) ? S_MEMREAD : S_MEMWRITE;
      end
      S_MEMREAD: begin
        in_mem            = 1'b1;
        ctrl_comb.mem_req = 1'b1;
        ctrl_comb.adr_src = 1'b1;
        if (mem.mem_ready) state_next = S_MEMWB;
      end
      S_MEMWB: begin
        ctrl_comb.result_src = 2'b01;
        ctrl_comb.reg_write  = 1'b1;
        state_next = S_FETCH;
      end
      S_MEMWRITE: begin
        in_mem              = 1'b1;
        ctrl_comb.mem_req   = 1'b1;
        ctrl_comb.adr_src   = 1'b1;
        ctrl_comb.mem_write = mem.mem_ready;
        if (mem.mem_ready) state_next = S_FETCH;
      end
      S_EXECR: begin
        ctrl_comb.alu_src_a = 2'b10;
        ctrl_comb.alu_op    = 2'b10;
        state_next = S_ALUWB;
      end
      S_EXECI: begin
        ctrl_comb.alu_src_a = 2'b10;
        ctrl_comb.alu_src_b = 2'b01;
        ctrl_comb.alu_op    = 2'b10;
        state_next = S_ALUWB;
      end
      S_ALUWB: begin
        ctrl_comb.reg_write = 1'b1;
        state_next = S_FETCH;
      end
      S_BEQ: begin
        ctrl_comb.alu_src_a = 2'b10;
        ctrl_comb.alu_op    = 2'b01;
        ctrl_comb.branch    = 1'b1;
        state_next = S_FETCH;
      end
      S_JAL: begin
        ctrl_comb.alu_src_a = 2'b01;
        ctrl_comb.alu_src_b = 2'b10;
        ctrl_comb.pc_update = 1'b1;
        state_next = S_ALUWB;
      end
      S_TRAP:  state_next = S_TRAP;
      default: state_next = S_FETCH;
    endcase

    // A ready arriving on the last allowed cycle still wins over the timeout.
    mem_wait = in_mem && !mem.mem_ready;
    if (TMO_EN && mem_wait && (cnt_reg == TMO_LAST)) begin
      state_next   = S_TRAP;
      bus_err_next = 1'b1;
    end

    if (state_next != state_reg) begin
      cnt_next = '0;
    end else if (mem_wait && (cnt_reg != {CNT_W{1'b1}})) begin
      cnt_next = cnt_reg + CNT_W'(1);
    end
  end

  assign ctrl_out    = reset ? '0 : ctrl_comb;
  assign mem.mem_req = ctrl_out.mem_req;
  assign AdrSrc      = ctrl_out.adr_src;
  assign IRWrite     = ctrl_out.ir_write;
  assign PCUpdate    = ctrl_out.pc_update;
  assign Branch      = ctrl_out.branch;
  assign MemWrite    = ctrl_out.mem_write;
  assign RegWrite    = ctrl_out.reg_write;
  assign ResultSrc   = ctrl_out.result_src;
  assign ALUSrcA     = ctrl_out.alu_src_a;
  assign ALUSrcB     = ctrl_out.alu_src_b;
  assign ALUOp       = ctrl_out.alu_op;
  assign illegal_op  = !reset && illegal_op_reg;
  assign bus_err     = !reset && bus_err_reg;
  assign state_o     = reset ? 4'd0 : state_reg;

endmodule

// File: tb/tb_multicycle_ctrl_fsm.sv
// Bench for multicycle_ctrl_fsm: two configurations driven side by side and checked every
// cycle against an instruction-route model, plus directed spot checks.
module tb_multicycle_ctrl_fsm;
  localparam logic [6:0] OP_LW  = 7'b0000011;
  localparam logic [6:0] OP_SW  = 7'b0100011;
  localparam logic [6:0] OP_R   = 7'b0110011;
  localparam logic [6:0] OP_I   = 7'b0010011;
  localparam logic [6:0] OP_BEQ = 7'b1100011;
  localparam logic [6:0] OP_JAL = 7'b1101111;
  localparam logic [6:0] OP_BAD = 7'b1111111;
  localparam int TMO_A = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       reset_a, reset_b;
  logic [6:0] op_a, op_b;
  multicycle_ctrl_fsm_if if_a ();
  multicycle_ctrl_fsm_if if_b ();

  logic a_AdrSrc, a_IRWrite, a_PCUpdate, a_Branch, a_MemWrite, a_RegWrite, a_illegal_op, a_bus_err;
  logic b_AdrSrc, b_IRWrite, b_PCUpdate, b_Branch, b_MemWrite, b_RegWrite, b_illegal_op, b_bus_err;
  logic [1:0] a_ResultSrc, a_ALUSrcA, a_ALUSrcB, a_ALUOp;
  logic [1:0] b_ResultSrc, b_ALUSrcA, b_ALUSrcB, b_ALUOp;
  logic [3:0] a_state_o, b_state_o;

  multicycle_ctrl_fsm #(.MEM_TIMEOUT(TMO_A), .ILLEGAL_TRAP(1'b1), .CNT_W(5)) dut_a (
    .clk(clk), .reset(reset_a), .op(op_a), .mem(if_a),
    .AdrSrc(a_AdrSrc), .IRWrite(a_IRWrite), .PCUpdate(a_PCUpdate), .Branch(a_Branch),
    .MemWrite(a_MemWrite), .RegWrite(a_RegWrite), .ResultSrc(a_ResultSrc), .ALUSrcA(a_ALUSrcA),
    .ALUSrcB(a_ALUSrcB), .ALUOp(a_ALUOp), .illegal_op(a_illegal_op), .bus_err(a_bus_err),
    .state_o(a_state_o)
  );

  multicycle_ctrl_fsm #(.MEM_TIMEOUT(0), .ILLEGAL_TRAP(1'b0), .CNT_W(5)) dut_b (
    .clk(clk), .reset(reset_b), .op(op_b), .mem(if_b),
    .AdrSrc(b_AdrSrc), .IRWrite(b_IRWrite), .PCUpdate(b_PCUpdate), .Branch(b_Branch),
    .MemWrite(b_MemWrite), .RegWrite(b_RegWrite), .ResultSrc(b_ResultSrc), .ALUSrcA(b_ALUSrcA),
    .ALUSrcB(b_ALUSrcB), .ALUOp(b_ALUOp), .illegal_op(b_illegal_op), .bus_err(b_bus_err),
    .state_o(b_state_o)
  );

  // {state, mem_req, AdrSrc, IRWrite, PCUpdate, Branch, MemWrite, RegWrite, ResultSrc, ALUSrcA, ALUSrcB, ALUOp, illegal, bus_err}
  logic [20:0] obs_a, obs_b;
  assign obs_a = {a_state_o, if_a.mem_req, a_AdrSrc, a_IRWrite, a_PCUpdate, a_Branch, a_MemWrite,
                  a_RegWrite, a_ResultSrc, a_ALUSrcA, a_ALUSrcB, a_ALUOp, a_illegal_op, a_bus_err};
  assign obs_b = {b_state_o, if_b.mem_req, b_AdrSrc, b_IRWrite, b_PCUpdate, b_Branch, b_MemWrite,
                  b_RegWrite, b_ResultSrc, b_ALUSrcA, b_ALUSrcB, b_ALUOp, b_illegal_op, b_bus_err};

  int n_cmp = 0;
  int n_bad = 0;
  int cyc = 0;

  // Model: each instruction is a route of phases; index 0 = a (timeout 4, trap), 1 = b (no timeout, NOP)
  int         rt[2][6];
  int         len[2], ph[2], wt[2], trap_age[2];
  bit         trap[2], ill[2], berr[2];
  logic [6:0] op[2];
  bit         rand_mode = 1'b0;
  logic [6:0] opq_a[$];
  logic [20:0] snap[2];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [6:0] rand_op();
    case ($urandom_range(0, 13))
      0, 1:    return OP_LW;
      2, 3:    return OP_SW;
      4, 5:    return OP_R;
      6, 7:    return OP_I;
      8, 9:    return OP_BEQ;
      10, 11:  return OP_JAL;
      12:      return OP_BAD;
      default: return 7'($urandom);
    endcase
  endfunction

  task automatic pick_op(input int m);
    if (m == 0 && opq_a.size() != 0) op[m] = opq_a.pop_front();
    else if (rand_mode) op[m] = rand_op();
  endtask

  task automatic build_route(input int m);
    rt[m][0] = 0; rt[m][1] = 1; ph[m] = 0; wt[m] = 0;
    case (op[m])
      OP_LW:   begin rt[m][2] = 2; rt[m][3] = 3; rt[m][4] = 4; len[m] = 5; end
      OP_SW:   begin rt[m][2] = 2; rt[m][3] = 5; len[m] = 4; end
      OP_R:    begin rt[m][2] = 6; rt[m][3] = 8; len[m] = 4; end
      OP_I:    begin rt[m][2] = 7; rt[m][3] = 8; len[m] = 4; end
      OP_BEQ:  begin rt[m][2] = 9; len[m] = 3; end
      OP_JAL:  begin rt[m][2] = 10; rt[m][3] = 8; len[m] = 4; end
      default: begin
        if (m == 0) begin rt[m][2] = 15; len[m] = 3; end
        else len[m] = 2;
      end
    endcase
  endtask

  task automatic advance(input int m, input bit rst, input bit rdy);
    int s;
    if (rst) begin
      trap[m] = 0; ill[m] = 0; berr[m] = 0;
      pick_op(m); build_route(m);
      return;
    end
    if (trap[m]) return;
    s = rt[m][ph[m]];
    if ((s == 0 || s == 3 || s == 5) && !rdy) begin
      wt[m]++;
      if (m == 0 && wt[m] == TMO_A) begin trap[m] = 1; berr[m] = 1; end
      return;
    end
    wt[m] = 0;
    ph[m]++;
    if (ph[m] == len[m]) begin
      pick_op(m); build_route(m);
    end else if (rt[m][ph[m]] == 15) begin
      trap[m] = 1; ill[m] = 1;
    end
  endtask

  function automatic logic [20:0] exp_vec(input int m, input bit rdy, input bit rst);
    logic mreq, adr, irw, pcu, br, mw, rw;
    logic [1:0] rs, sa, sb, aop;
    int s;
    {mreq, adr, irw, pcu, br, mw, rw} = '0;
    {rs, sa, sb, aop} = '0;
    if (rst) return '0;
    s = trap[m] ? 15 : rt[m][ph[m]];
    case (s)
      0:  begin mreq = 1; sb = 2'b10; rs = 2'b10; irw = rdy; pcu = rdy; end
      1:  begin sa = 2'b01; sb = 2'b01; end
      2:  begin sa = 2'b10; sb = 2'b01; end
      3:  begin mreq = 1; adr = 1; end
      4:  begin rs = 2'b01; rw = 1; end
      5:  begin mreq = 1; adr = 1; mw = rdy; end
      6:  begin sa = 2'b10; aop = 2'b10; end
      7:  begin sa = 2'b10; sb = 2'b01; aop = 2'b10; end
      8:  rw = 1;
      9:  begin sa = 2'b10; aop = 2'b01; br = 1; end
      10: begin sa = 2'b01; sb = 2'b10; pcu = 1; end
      default: ;
    endcase
    return {4'(s), mreq, adr, irw, pcu, br, mw, rw, rs, sa, sb, aop, ill[m], berr[m]};
  endfunction

  task automatic step(input bit ra, input bit ya, input bit rb, input bit yb);
    reset_a = ra; reset_b = rb;
    if_a.mem_ready = ya; if_b.mem_ready = yb;
    op_a = op[0]; op_b = op[1];
    @(negedge clk);
    snap[0] = obs_a; snap[1] = obs_b;
    check($sformatf("a.cyc%0d", cyc), 32'(obs_a), 32'(exp_vec(0, ya, ra)));
    check($sformatf("b.cyc%0d", cyc), 32'(obs_b), 32'(exp_vec(1, yb, rb)));
    @(posedge clk);
    advance(0, ra, ya);
    advance(1, rb, yb);
    #1;
    cyc++;
  endtask

  initial begin
    int lw_seq[5];
    bit ra, rb;
    lw_seq = '{0, 1, 2, 3, 4};
    op[0] = OP_LW; op[1] = OP_BAD;
    trap = '{0, 0}; ill = '{0, 0}; berr = '{0, 0}; trap_age = '{0, 0};
    build_route(0); build_route(1);
    reset_a = 1'b1; reset_b = 1'b1; if_a.mem_ready = 1'b1; if_b.mem_ready = 1'b1;
    op_a = op[0]; op_b = op[1];
    @(posedge clk); #1;

    repeat (3) begin
      step(1, 1, 1, 1);
      check("rst_all_zero", 32'(snap[0]), 32'd0);
    end
    opq_a = '{OP_SW, OP_BEQ, OP_JAL, OP_BAD, OP_LW, OP_LW};

    // lw with ready held high; b runs the unknown opcode as a NOP
    for (int i = 0; i < 5; i++) begin
      step(0, 1, 0, 1);
      check("lw_state", 32'(snap[0][20:17]), 32'(lw_seq[i]));
      check("b_nop_state", 32'(snap[1][20:17]), 32'(i % 2));
      if (i == 0) check("post_rst_fetch", 32'({snap[0][16], snap[0][14]}), 32'(2'b11));
      if (i == 3) check("lw_no_rw_memread", 32'(snap[0][10]), 32'd0);
      if (i == 4) check("lw_memwb", 32'({snap[0][10], snap[0][9:8]}), 32'(3'b101));
    end
    check("b_no_flag", 32'(snap[1][1:0]), 32'd0);

    // sw with a 3-cycle stall in MEMWRITE
    for (int i = 0; i < 3; i++) step(0, 1, 0, 1);
    repeat (3) begin
      step(0, 0, 0, 1);
      check("sw_hold", 32'({snap[0][20:17], snap[0][16], snap[0][11]}), 32'({4'd5, 1'b1, 1'b0}));
    end
    step(0, 1, 0, 1);
    check("sw_strobe", 32'({snap[0][20:17], snap[0][11]}), 32'({4'd5, 1'b1}));

    // beq 0,1,9
    step(0, 1, 0, 1);
    check("beq_fetch", 32'(snap[0][20:17]), 32'd0);
    step(0, 1, 0, 1);
    step(0, 1, 0, 1);
    check("beq_exec", 32'({snap[0][20:17], snap[0][12], snap[0][3:2]}), 32'({4'd9, 1'b1, 2'b01}));

    // jal 0,1,10,8
    step(0, 1, 0, 1);
    step(0, 1, 0, 1);
    step(0, 1, 0, 1);
    check("jal_state", 32'({snap[0][20:17], snap[0][13]}), 32'({4'd10, 1'b1}));
    step(0, 1, 0, 1);
    check("jal_aluwb", 32'({snap[0][20:17], snap[0][10]}), 32'({4'd8, 1'b1}));

    // unknown opcode traps a and stays trapped
    step(0, 1, 0, 1);
    step(0, 1, 0, 1);
    repeat (3) begin
      step(0, 1, 0, 1);
      check("illegal_trap", 32'({snap[0][20:17], snap[0][16], snap[0][1:0]}), 32'({4'd15, 1'b0, 2'b10}));
    end

    // fetch timeout: four stalled cycles
    step(1, 1, 0, 1);
    repeat (4) step(0, 0, 0, 1);
    step(0, 0, 0, 1);
    check("timeout_trap", 32'({snap[0][20:17], snap[0][1:0]}), 32'({4'd15, 2'b01}));

    // ready on the fourth stalled cycle still advances
    step(1, 1, 0, 1);
    repeat (3) step(0, 0, 0, 1);
    step(0, 1, 0, 1);
    check("ready_last_cycle", 32'({snap[0][20:17], snap[0][14]}), 32'({4'd0, 1'b1}));
    step(0, 1, 0, 1);
    check("no_bus_err", 32'({snap[0][20:17], snap[0][0]}), 32'({4'd1, 1'b0}));
    repeat (3) step(0, 1, 0, 1);

    rand_mode = 1'b1;
    for (int k = 0; k < 4000; k++) begin
      ra = (trap_age[0] > 2) || ($urandom_range(0, 99) == 0);
      rb = (trap_age[1] > 2) || ($urandom_range(0, 99) == 0);
      step(ra, $urandom_range(0, 99) < 65, rb, $urandom_range(0, 99) < 70);
      for (int m = 0; m < 2; m++) trap_age[m] = trap[m] ? trap_age[m] + 1 : 0;
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
